usb_uart_tx: RTL and testbench

- UART transmit stage directly downstream of the USB CDC line-coding decoder.
- Consumes the decoded line coding (baud rate, stop-bit code, parity code, data bits, enable) plus a byte stream from the UART1 data endpoint (endpoint 1), and serializes it on a single TX pin.
- Computes the baud divisor in hardware with a sequential divider whenever the baud rate changes.

---
 rtl/usb_uart_tx.sv | 274 +++++++++++++++++++++++++++
 tb/tb_usb_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_tx.sv
// usb_uart_tx: UART transmitter driven by the USB CDC line coding and the endpoint-1 byte stream.
// Define USB_UART_TX_FIFO_EN to replace the single holding register with a 2^FIFO_AW x 8 FIFO.
module usb_uart_tx #(
   parameter int unsigned CLK_FREQ = 60000000,
   parameter int unsigned FIFO_AW  = 4
) (
   input  logic        PHY_CLKOUT,
   input  logic        RESETN_IN,
   input  logic        uart_en_i,
   input  logic [31:0] baud_rate_i,
   input  logic [7:0]  stop_bit_i,
   input  logic [7:0]  parity_bit_i,
   input  logic [7:0]  data_bits_i,
   input  logic [7:0]  tx_dat_i,
   input  logic        tx_val_i,
   output logic        tx_rdy_o,
   output logic        uart_tx_o,
   output logic        tx_busy_o,
   output logic        cfg_err_o
);
   // state  | meaning
   // IDLE   | line high; watch for baud change or a buffered byte
   // CALC   | restoring divider, one quotient bit per cycle
   // START  | start bit (low)
   // DATA   | data bits, LSB first
   // PARITY | parity bit
   // STOP   | stop time (1, 1.5 or 2 bits)
   typedef enum logic [2:0] {IDLE, CALC, START, DATA, PARITY, STOP} state_t;

   localparam logic [31:0] CLK_F    = 32'(CLK_FREQ);
   localparam logic [31:0] DIV_RST  = 32'(CLK_FREQ / 115200);
   localparam logic [31:0] BAUD_RST = 32'd115200;

   state_t      state, state_nxt;
   logic        buf_vld, buf_pop, push;
   logic [7:0]  buf_dat;
   logic [31:0] baud_q, divisor, timer, stop_len;
   logic [31:0] den, dvd, rem, rem_sub, quo_nxt;
   logic [30:0] quo;
   logic [32:0] rem_sh;
   logic        q_bit;
   logic [4:0]  calc_cnt;
   logic [7:0]  sh, mask, par_data;
   logic [2:0]  bit_idx, last_idx, last_nxt;
   logic        par_en_q, par_q, par_en_nxt, par_nxt;
   logic [1:0]  stop_sel;
   logic        cfg_err, baud_chg, can_start, bit_end;
   logic        ld_frame, ld_bit, ld_stop, shift, start_calc, zero_baud;

   assign push = tx_val_i & tx_rdy_o;

`ifdef USB_UART_TX_FIFO_EN
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   fifo_cnt;

   assign tx_rdy_o = uart_en_i & (fifo_cnt != DEPTH[FIFO_AW:0]);
   assign buf_vld  = fifo_cnt != '0;
   assign buf_dat  = mem[rd_ptr];

   always_ff @(posedge PHY_CLKOUT) begin
      if (push) mem[wr_ptr] <= tx_dat_i;
   end

   always_ff @(posedge PHY_CLKOUT or negedge RESETN_IN) begin
      if (!RESETN_IN) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)    wr_ptr <= wr_ptr + 1'b1;
         if (buf_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, buf_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: ;
         endcase
      end
   end
`else
   assign tx_rdy_o = uart_en_i & ~buf_vld;

   always_ff @(posedge PHY_CLKOUT or negedge RESETN_IN) begin
      if (!RESETN_IN) begin
         buf_vld <= 1'b0;
         buf_dat <= '0;
      end else if (push) begin
         buf_vld <= 1'b1;
         buf_dat <= tx_dat_i;
      end else if (buf_pop) begin
         buf_vld <= 1'b0;
      end
   end
`endif

   assign baud_chg  = baud_rate_i != baud_q;
   assign can_start = uart_en_i & buf_vld;
   assign bit_end   = timer == '0;
   assign tx_busy_o = (state != IDLE) | buf_vld | baud_chg;
   assign cfg_err_o = cfg_err;

   always_ff @(posedge PHY_CLKOUT or negedge RESETN_IN) begin
      if (!RESETN_IN) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      buf_pop    = 1'b0;
      ld_frame   = 1'b0;
      ld_bit     = 1'b0;
      ld_stop    = 1'b0;
      shift      = 1'b0;
      start_calc = 1'b0;
      zero_baud  = 1'b0;
      case (state)
         IDLE: begin
            if (baud_chg) begin
               if (baud_rate_i == '0) zero_baud = 1'b1;
               else begin
                  start_calc = 1'b1;
                  state_nxt  = CALC;
               end
            end else if (can_start) begin
               ld_frame  = 1'b1;
               buf_pop   = 1'b1;
               state_nxt = START;
            end
         end
         CALC:  if (calc_cnt == 5'd31) state_nxt = IDLE;
         START: if (bit_end) begin
            ld_bit    = 1'b1;
            state_nxt = DATA;
         end
         DATA: if (bit_end) begin
            if (bit_idx != last_idx) begin
               ld_bit = 1'b1;
               shift  = 1'b1;
            end else if (par_en_q) begin
               ld_bit    = 1'b1;
               state_nxt = PARITY;
            end else begin
               ld_stop   = 1'b1;
               state_nxt = STOP;
            end
         end
         PARITY: if (bit_end) begin
            ld_stop   = 1'b1;
            state_nxt = STOP;
         end
         STOP: if (bit_end) begin
            // chain straight into the next frame so back-to-back bytes have no idle gap
            if (!baud_chg && can_start) begin
               ld_frame  = 1'b1;
               buf_pop   = 1'b1;
               state_nxt = START;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      last_nxt = 3'd7;
      mask     = 8'hFF;
      case (data_bits_i)
         8'd5:    begin last_nxt = 3'd4; mask = 8'h1F; end
         8'd6:    begin last_nxt = 3'd5; mask = 8'h3F; end
         8'd7:    begin last_nxt = 3'd6; mask = 8'h7F; end
         default: ;
      endcase
      par_data   = buf_dat & mask;
      par_en_nxt = 1'b1;
      par_nxt    = 1'b0;
      case (parity_bit_i)
         8'd1:    par_nxt = ~^par_data;
         8'd2:    par_nxt = ^par_data;
         8'd3:    par_nxt = 1'b1;
         8'd4:    par_nxt = 1'b0;
         default: par_en_nxt = 1'b0;
      endcase
      case (stop_sel)
         2'd0:    stop_len = divisor;
         2'd1:    stop_len = divisor + (divisor >> 1);
         default: stop_len = divisor << 1;
      endcase
      uart_tx_o = 1'b1;
      case (state)
         START:   uart_tx_o = 1'b0;
         DATA:    uart_tx_o = sh[0];
         PARITY:  uart_tx_o = par_q;
         default: ;
      endcase
   end

   always_ff @(posedge PHY_CLKOUT or negedge RESETN_IN) begin
      if (!RESETN_IN) begin
         timer    <= '0;
         sh       <= '0;
         bit_idx  <= '0;
         last_idx <= 3'd7;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop_sel <= '0;
      end else begin
         if (ld_frame) begin
            timer    <= divisor - 1'b1;
            sh       <= buf_dat;
            bit_idx  <= '0;
            last_idx <= last_nxt;
            par_en_q <= par_en_nxt;
            par_q    <= par_nxt;
            stop_sel <= (stop_bit_i == 8'd0) ? 2'd0 : (stop_bit_i == 8'd1) ? 2'd1 : 2'd2;
         end else if (ld_bit) begin
            timer <= divisor - 1'b1;
         end else if (ld_stop) begin
            timer <= stop_len - 1'b1;
         end else if (!bit_end) begin
            timer <= timer - 1'b1;
         end
         if (shift) begin
            sh      <= sh >> 1;
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   assign rem_sh  = {rem, dvd[31]};
   assign q_bit   = rem_sh >= {1'b0, den};
   assign rem_sub = rem_sh[31:0] - den;
   assign quo_nxt = {quo, q_bit};

   // divisor only changes on a clean quotient; a bad request keeps the old timing
   always_ff @(posedge PHY_CLKOUT or negedge RESETN_IN) begin
      if (!RESETN_IN) begin
         baud_q   <= BAUD_RST;
         divisor  <= DIV_RST;
         cfg_err  <= 1'b0;
         den      <= '0;
         dvd      <= '0;
         rem      <= '0;
         quo      <= '0;
         calc_cnt <= '0;
      end else begin
         if (zero_baud) begin
            cfg_err <= 1'b1;
            baud_q  <= '0;
         end
         if (start_calc) begin
            baud_q   <= baud_rate_i;
            den      <= baud_rate_i;
            dvd      <= CLK_F;
            rem      <= '0;
            quo      <= '0;
            calc_cnt <= '0;
         end else if (state == CALC) begin
            rem      <= q_bit ? rem_sub : rem_sh[31:0];
            dvd      <= dvd << 1;
            quo      <= quo_nxt[30:0];
            calc_cnt <= calc_cnt + 1'b1;
            if (calc_cnt == 5'd31) begin
               if (quo_nxt < 32'd16) cfg_err <= 1'b1;
               else begin
                  divisor <= quo_nxt;
                  cfg_err <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_usb_uart_tx.sv
// tb_usb_uart_tx: directed bench for usb_uart_tx; clock scaled to 6 MHz so divisors are
// 52 @115200, 625 @9600, 26 @230400, 16 @375000 and 15 (rejected) @400000.
module tb_usb_uart_tx;
   localparam int unsigned CLK_FREQ = 6000000;
   localparam int TIMEOUT = 20000;
`ifdef USB_UART_TX_FIFO_EN
   localparam int FIFO_ACCEPT = 4;
`else
   localparam int FIFO_ACCEPT = 1;
`endif

   logic        PHY_CLKOUT = 1'b0;
   logic        RESETN_IN;
   logic        uart_en_i;
   logic [31:0] baud_rate_i;
   logic [7:0]  stop_bit_i, parity_bit_i, data_bits_i, tx_dat_i;
   logic        tx_val_i, tx_rdy_o, uart_tx_o, tx_busy_o, cfg_err_o;

   int n_checks = 0;
   int n_fail   = 0;
   int k;
   logic [7:0] fifo_vec [5];

   always #5 PHY_CLKOUT = ~PHY_CLKOUT;

   usb_uart_tx #(.CLK_FREQ(CLK_FREQ), .FIFO_AW(2)) dut (
      .PHY_CLKOUT   (PHY_CLKOUT),
      .RESETN_IN    (RESETN_IN),
      .uart_en_i    (uart_en_i),
      .baud_rate_i  (baud_rate_i),
      .stop_bit_i   (stop_bit_i),
      .parity_bit_i (parity_bit_i),
      .data_bits_i  (data_bits_i),
      .tx_dat_i     (tx_dat_i),
      .tx_val_i     (tx_val_i),
      .tx_rdy_o     (tx_rdy_o),
      .uart_tx_o    (uart_tx_o),
      .tx_busy_o    (tx_busy_o),
      .cfg_err_o    (cfg_err_o)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      tx_dat_i = b;
      tx_val_i = 1'b1;
      while (tx_rdy_o !== 1'b1 && n < TIMEOUT) begin
         @(negedge PHY_CLKOUT);
         n++;
      end
      check_val("send_rdy", tx_rdy_o, 1);
      @(negedge PHY_CLKOUT);
      tx_val_i = 1'b0;
   endtask

   // called on a falling edge; returns on the falling edge of the first cycle after stop
   task automatic expect_frame(input string tag, input logic [11:0] bits, input int nb,
                               input int div, input int stop_cyc, input int exp_gap);
      int gap = 0;
      int errs = 0;
      int total = nb * div + stop_cyc;
      logic exp_bit;
      while (uart_tx_o !== 1'b0 && gap < TIMEOUT) begin
         @(negedge PHY_CLKOUT);
         gap++;
      end
      check_val({tag, "_start"}, uart_tx_o, 0);
      if (exp_gap >= 0) check_val({tag, "_gap"}, gap, exp_gap);
      for (int i = 0; i < total; i++) begin
         exp_bit = (i < nb * div) ? bits[i / div] : 1'b1;
         if (uart_tx_o !== exp_bit) errs++;
         @(negedge PHY_CLKOUT);
      end
      check_val({tag, "_wave"}, errs, 0);
   endtask

   task automatic change_baud(input string tag, input logic [31:0] baud, input int exp_busy);
      int n = 0;
      baud_rate_i = baud;
      #1;
      while (tx_busy_o === 1'b1 && n < 200) begin
         n++;
         @(negedge PHY_CLKOUT);
      end
      check_val({tag, "_busy"}, n, exp_busy);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      fifo_vec = '{8'h31, 8'hC4, 8'h7E, 8'h01, 8'hF0};
      RESETN_IN = 1'b0; uart_en_i = 1'b0; baud_rate_i = 32'd115200;
      stop_bit_i = 8'd0; parity_bit_i = 8'd0; data_bits_i = 8'd8;
      tx_dat_i = 8'h00; tx_val_i = 1'b0;
      repeat (3) @(negedge PHY_CLKOUT);
      check_val("rst_tx", uart_tx_o, 1);
      check_val("rst_rdy", tx_rdy_o, 0);
      check_val("rst_busy", tx_busy_o, 0);
      check_val("rst_err", cfg_err_o, 0);
      RESETN_IN = 1'b1;
      @(negedge PHY_CLKOUT);
      uart_en_i = 1'b1;
      #1 check_val("rdy_en", tx_rdy_o, 1);
      @(negedge PHY_CLKOUT);

      // 0x55 8N1 at reset divisor
      send_byte(8'h55);
      expect_frame("f55", {3'b000, 8'h55, 1'b0}, 9, 52, 52, 1);

      // 9600, even parity, 2 stop: 0xA3 has four ones -> parity 0
      change_baud("b9600", 9600, 33);
      check_val("err_9600", cfg_err_o, 0);
      parity_bit_i = 8'd2; stop_bit_i = 8'd2;
      send_byte(8'hA3);
      expect_frame("fa3", {2'b00, 1'b0, 8'hA3, 1'b0}, 10, 625, 1250, 1);

      // 7 data bits, odd parity, 1.5 stop: 0x80 -> seven zeros, parity 1
      change_baud("b115k", 115200, 33);
      data_bits_i = 8'd7; parity_bit_i = 8'd1; stop_bit_i = 8'd1;
      send_byte(8'h80);
      expect_frame("f80", {3'b000, 1'b1, 7'h00, 1'b0}, 9, 52, 78, 1);
      data_bits_i = 8'd8; parity_bit_i = 8'd0; stop_bit_i = 8'd0;

      // bad baud values keep the old divisor
      change_baud("b0", 0, 1);
      check_val("err_b0", cfg_err_o, 1);
      change_baud("b400k", 400000, 33);
      check_val("err_400k", cfg_err_o, 1);
      send_byte(8'h5A);
      expect_frame("f5a", {3'b000, 8'h5A, 1'b0}, 9, 52, 52, 1);
      change_baud("b115k_2", 115200, 33);
      check_val("err_clr", cfg_err_o, 0);
      change_baud("b375k", 375000, 33);
      check_val("err_375k", cfg_err_o, 0);
      send_byte(8'hC3);
      expect_frame("fc3", {3'b000, 8'hC3, 1'b0}, 9, 16, 16, 1);
      change_baud("b115k_3", 115200, 33);

      // enable dropped mid-DATA with a second byte buffered
      fork
         begin
            send_byte(8'h0F);
            send_byte(8'h3C);
         end
         expect_frame("f0f", {3'b000, 8'h0F, 1'b0}, 9, 52, 52, -1);
         begin
            repeat (200) @(negedge PHY_CLKOUT);
            uart_en_i = 1'b0;
         end
      join
      check_val("dis_rdy", tx_rdy_o, 0);
      check_val("dis_busy", tx_busy_o, 1);
      k = 0;
      for (int i = 0; i < 100; i++) begin
         if (uart_tx_o !== 1'b1) k++;
         @(negedge PHY_CLKOUT);
      end
      check_val("dis_line", k, 0);
      uart_en_i = 1'b1;
      expect_frame("f3c", {3'b000, 8'h3C, 1'b0}, 9, 52, 52, 1);

      // bytes pushed while the divider runs, then a back-to-back stream at 230400
      baud_rate_i = 32'd230400;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         tx_dat_i = fifo_vec[k];
         tx_val_i = 1'b1;
         #1;
         if (tx_rdy_o === 1'b1) k++;
         @(negedge PHY_CLKOUT);
      end
      check_val("buf_accept", k, FIFO_ACCEPT);
      fork
         begin
            for (int i = k; i < 5; i++) send_byte(fifo_vec[i]);
            tx_val_i = 1'b0;
         end
         begin
            expect_frame("s0", {3'b000, 8'h31, 1'b0}, 9, 26, 26, -1);
            expect_frame("s1", {3'b000, 8'hC4, 1'b0}, 9, 26, 26, 0);
            expect_frame("s2", {3'b000, 8'h7E, 1'b0}, 9, 26, 26, 0);
            expect_frame("s3", {3'b000, 8'h01, 1'b0}, 9, 26, 26, 0);
            expect_frame("s4", {3'b000, 8'hF0, 1'b0}, 9, 26, 26, 0);
         end
      join
      check_val("s_idle_busy", tx_busy_o, 0);

      // reset during a frame returns the line high at once
      send_byte(8'hAA);
      repeat (5) @(negedge PHY_CLKOUT);
      check_val("pre_rst_line", uart_tx_o, 0);
      baud_rate_i = 32'd115200;
      RESETN_IN = 1'b0;
      #1;
      check_val("mid_rst_line", uart_tx_o, 1);
      check_val("mid_rst_busy", tx_busy_o, 0);
      @(negedge PHY_CLKOUT);
      RESETN_IN = 1'b1;
      @(negedge PHY_CLKOUT);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
